mac_tx: RTL and testbench

//  Ethernet MAC transmit path, counterpart of mac_rx. Accepts one frame as a byte stream
//  (dest MAC .. payload, no preamble/FCS) into an internal single-frame buffer, then

---
 rtl/mac_tx.sv | 157 +++++++++++++++
 tb/tb_mac_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx.sv
// Ethernet MAC transmit path: buffers one frame, then sends preamble/SFD, data, zero pad,
// FCS and inter-packet gap to the PHY as one nibble per clock, low nibble first.
module mac_tx #(
  parameter int unsigned BUF_DEPTH      = 1518,
  parameter int unsigned MIN_FRAME      = 60,
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned IPG_BYTES      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       config_ready,
  input  logic       tx_wr_en,
  input  logic [7:0] tx_data_in,
  input  logic       tx_wr_last,
  output logic       tx_wr_ready,
  output logic [3:0] phy_txd,
  output logic       phy_tx_ctl,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned CW   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned MAXN = 2 * (BUF_DEPTH + MIN_FRAME + IPG_BYTES + PREAMBLE_BYTES + 2);
  localparam int unsigned NW   = $clog2(MAXN);
  localparam logic [NW-1:0] PRE_LAST = NW'(2 * PREAMBLE_BYTES + 1);
  localparam logic [NW-1:0] IPG_LAST = NW'(2 * IPG_BYTES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_CFG, PREAMBLE, DATA, PAD, FCS, IPG} state_t;

  state_t        state, state_nxt;
  logic [NW-1:0] cnt;
  logic [NW-1:0] nxt_byte;
  logic [CW-1:0] count, len;
  logic          ovf;
  logic [7:0]    mem [BUF_DEPTH];
  logic [7:0]    rd_q;
  logic [AW-1:0] rd_addr;
  logic [31:0]   crc;
  logic [31:0]   fcs;
  logic [3:0]    txd_d;
  logic          ctl_d;
  logic          wr_acc, wr_full, drop, queue, busy_d;
  logic          data_last, pad_last, need_pad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign wr_acc    = tx_wr_en & tx_wr_ready;
  assign wr_full   = (count == CW'(BUF_DEPTH));
  assign drop      = wr_acc & tx_wr_last & (ovf | wr_full);
  assign queue     = wr_acc & tx_wr_last & ~(ovf | wr_full);
  assign need_pad  = (32'(len) < MIN_FRAME);
  assign data_last = (cnt == NW'(2 * 32'(len) - 1));
  assign pad_last  = (cnt == NW'(2 * (MIN_FRAME - 32'(len)) - 1));
  assign busy_d    = (state != IDLE) || (state_nxt != IDLE);

  // Read one byte ahead so rd_q already holds byte 0 on the first DATA cycle.
  assign nxt_byte = (cnt + 1'b1) >> 1;
  assign rd_addr  = (state == DATA && nxt_byte < NW'(BUF_DEPTH)) ? AW'(nxt_byte) : '0;

  always_ff @(posedge clk) begin
    if (wr_acc && !wr_full)
      mem[count[AW-1:0]] <= tx_data_in;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      count       <= '0;
      len         <= '0;
      ovf         <= 1'b0;
      crc         <= '0;
      phy_txd     <= '0;
      phy_tx_ctl  <= 1'b0;
      tx_wr_ready <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == IDLE || state == WAIT_CFG)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (wr_acc) begin
        if (tx_wr_last) begin
          count <= '0;
          ovf   <= 1'b0;
          if (queue)
            len <= count + 1'b1;
        end else if (wr_full) begin
          ovf <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      case (state)
        PREAMBLE: crc <= '1;
        DATA:     if (cnt[0]) crc <= crc_byte(crc, rd_q);
        PAD:      if (cnt[0]) crc <= crc_byte(crc, 8'h00);
        default:  ;
      endcase
      phy_txd     <= txd_d;
      phy_tx_ctl  <= ctl_d;
      tx_done     <= (state == IPG) && (cnt == IPG_LAST);
      tx_error    <= drop;
      tx_busy     <= busy_d;
      tx_wr_ready <= !busy_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (queue) state_nxt = WAIT_CFG;
      WAIT_CFG: if (config_ready) state_nxt = PREAMBLE;
      PREAMBLE: if (cnt == PRE_LAST) state_nxt = DATA;
      DATA:     if (data_last) state_nxt = need_pad ? PAD : FCS;
      PAD:      if (pad_last) state_nxt = FCS;
      FCS:      if (cnt[2:0] == 3'd7) state_nxt = IPG;
      IPG:      if (cnt == IPG_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    txd_d = '0;
    ctl_d = 1'b0;
    fcs   = ~crc;
    case (state)
      PREAMBLE: begin
        ctl_d = 1'b1;
        txd_d = (cnt == PRE_LAST) ? 4'hD : 4'h5;
      end
      DATA: begin
        ctl_d = 1'b1;
        txd_d = cnt[0] ? rd_q[7:4] : rd_q[3:0];
      end
      PAD: ctl_d = 1'b1;
      FCS: begin
        ctl_d = 1'b1;
        txd_d = fcs[{cnt[2:0], 2'b00} +: 4];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_tx.sv
// Scoreboard bench for mac_tx: a default-parameter instance and a small-buffer no-pad instance.
module tb_mac_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, cfg_a, wr_en_a, last_a, ready_a, ctl_a, busy_a, done_a, err_a;
  logic [7:0] dat_a;
  logic [3:0] txd_a;
  logic       rst_b, cfg_b, wr_en_b, last_b, ready_b, ctl_b, busy_b, done_b, err_b;
  logic [7:0] dat_b;
  logic [3:0] txd_b;

  mac_tx dut_a (
    .clk(clk), .rst(rst_a), .config_ready(cfg_a), .tx_wr_en(wr_en_a), .tx_data_in(dat_a),
    .tx_wr_last(last_a), .tx_wr_ready(ready_a), .phy_txd(txd_a), .phy_tx_ctl(ctl_a),
    .tx_busy(busy_a), .tx_done(done_a), .tx_error(err_a)
  );

  mac_tx #(.BUF_DEPTH(16), .MIN_FRAME(0)) dut_b (
    .clk(clk), .rst(rst_b), .config_ready(cfg_b), .tx_wr_en(wr_en_b), .tx_data_in(dat_b),
    .tx_wr_last(last_b), .tx_wr_ready(ready_b), .phy_txd(txd_b), .phy_tx_ctl(ctl_b),
    .tx_busy(busy_b), .tx_done(done_b), .tx_error(err_b)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         exp_len[$];
  logic [7:0] rx_q[$];
  bit         ignore = 1'b0;
  int         nib_cnt = 0;
  logic [3:0] lo_nib;
  bit         prev_ctl = 1'b0;
  int         gap = 0;
  bit         gap_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i])
      for (int k = 0; k < 8; k++) begin
        logic fb;
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] b[$], input int minf);
    logic [7:0] body[$];
    logic [31:0] fcs;
    body = b;
    while (body.size() < minf) body.push_back(8'h00);
    fcs = ~crc_model(body);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    exp_len.push_back(8 + body.size() + 4);
  endtask

  // Monitor: reassembles bytes while ctl is high and scores them at the end of each frame.
  always @(negedge clk) begin
    logic       mctl;
    logic [3:0] mtxd;
    int         l;
    logic [7:0] got;
    mctl = ctl_a | ctl_b;
    mtxd = ctl_a ? txd_a : txd_b;
    if (!ctl_a) check("txd_idle_a", txd_a, 0);
    if (!ctl_b) check("txd_idle_b", txd_b, 0);
    if (mctl) begin
      if (nib_cnt[0]) rx_q.push_back({mtxd, lo_nib});
      else lo_nib = mtxd;
      nib_cnt++;
    end else if (prev_ctl) begin
      if (!ignore) begin
        if (exp_len.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got=%0d nibbles exp=none", nib_cnt);
        end else begin
          l = exp_len.pop_front();
          check("frame_nibbles", nib_cnt, 2 * l);
          for (int i = 0; i < l; i++) begin
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            check($sformatf("byte[%0d]", i), got, exp_q.pop_front());
          end
          gap_on = 1'b1;
          gap = 0;
        end
      end
      rx_q.delete();
      nib_cnt = 0;
    end
    if (gap_on && !mctl) begin
      gap++;
      if (done_a | done_b) begin
        check("ipg_to_done", gap, 24);
        gap_on = 1'b0;
      end else if (gap > 100) begin
        check("done_timeout", gap, 24);
        gap_on = 1'b0;
      end
    end
    prev_ctl = mctl;
  end

  task automatic write_frame(input int d, input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) begin
      if (d == 0) begin wr_en_a = 1'b1; dat_a = b[i]; last_a = (i == b.size() - 1); end
      else        begin wr_en_b = 1'b1; dat_b = b[i]; last_b = (i == b.size() - 1); end
      @(negedge clk);
    end
    wr_en_a = 1'b0; last_a = 1'b0; wr_en_b = 1'b0; last_b = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int k;
    @(negedge clk);
    for (k = 0; k < 5000 && (d == 0 ? busy_a : busy_b); k++) @(negedge clk);
    check("wait_idle_busy", d == 0 ? busy_a : busy_b, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string tag, input int d);
    if (d == 0) begin
      check({tag, "_txd"}, txd_a, 0);   check({tag, "_ctl"}, ctl_a, 0);
      check({tag, "_ready"}, ready_a, 1); check({tag, "_busy"}, busy_a, 0);
      check({tag, "_done"}, done_a, 0); check({tag, "_err"}, err_a, 0);
    end else begin
      check({tag, "_txd"}, txd_b, 0);   check({tag, "_ctl"}, ctl_b, 0);
      check({tag, "_ready"}, ready_b, 1); check({tag, "_busy"}, busy_b, 0);
      check({tag, "_done"}, done_b, 0); check({tag, "_err"}, err_b, 0);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    int k;
    bit seen;
    rst_a = 1'b1; rst_b = 1'b1; cfg_a = 1'b1; cfg_b = 1'b1;
    wr_en_a = 1'b0; last_a = 1'b0; dat_a = '0;
    wr_en_b = 1'b0; last_b = 1'b0; dat_b = '0;
    repeat (3) @(negedge clk);
    check_reset("rst_a", 0);
    check_reset("rst_b", 1);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // "123456789", no padding, hand-computed FCS bytes 26 39 F4 CB.
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (q[i]) exp_q.push_back(q[i]);
    exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
    exp_len.push_back(21);
    write_frame(1, q);
    wait_idle(1);

    // 20 bytes into a 16-byte buffer: dropped with an error pulse.
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'(i * 3 + 1));
    write_frame(1, q);
    check("ovf_error", err_b, 1);
    check("ovf_ready", ready_b, 1);
    check("ovf_busy", busy_b, 0);
    @(negedge clk);
    check("ovf_error_pulse", err_b, 0);
    seen = 1'b0;
    repeat (30) begin @(negedge clk); seen |= ctl_b; end
    check("ovf_no_tx", seen, 0);

    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'hA0 + 8'(i));
    push_frame(q, 0);
    write_frame(1, q);
    wait_idle(1);

    // Header + payload of 26 bytes, padded to 60.
    q = {};
    for (int i = 0; i < 26; i++) q.push_back(8'(i * 7 + 3));
    push_frame(q, 60);
    write_frame(0, q);
    wait_idle(0);

    q = {};
    for (int i = 0; i < 64; i++) q.push_back(8'(255 - i * 5));
    push_frame(q, 60);
    write_frame(0, q);
    wait_idle(0);

    // Held in WAIT_CFG until config_ready, which later drops mid-DATA.
    cfg_a = 1'b0;
    q = {};
    for (int i = 0; i < 30; i++) q.push_back(8'(i * 11 + 5));
    push_frame(q, 60);
    write_frame(0, q);
    repeat (10) @(negedge clk);
    check("cfg_hold_ctl", ctl_a, 0);
    check("cfg_hold_busy", busy_a, 1);
    cfg_a = 1'b1;
    for (k = 0; k < 5 && !ctl_a; k++) @(negedge clk);
    check("cfg_start_latency", (k >= 1 && k <= 2), 1);
    repeat (24) @(negedge clk);
    cfg_a = 1'b0;
    wait_idle(0);
    cfg_a = 1'b1;

    // Reset during DATA: frame abandoned, no tx_done.
    ignore = 1'b1;
    q = {};
    for (int i = 0; i < 64; i++) q.push_back(8'(i));
    write_frame(0, q);
    for (k = 0; k < 100 && !ctl_a; k++) @(negedge clk);
    check("rst_mid_started", ctl_a, 1);
    repeat (30) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check_reset("rst_mid", 0);
    rst_a = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= done_a; end
    check("rst_mid_no_done", seen, 0);
    ignore = 1'b0;

    q = {};
    for (int i = 0; i < 12; i++) q.push_back(8'h10 + 8'(i));
    push_frame(q, 60);
    write_frame(0, q);
    wait_idle(0);

    check("frames_pending", exp_len.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
